// File: rtl/psum_writeback.sv
// Partial-sum writeback: streams psum vectors into SRAM, accumulating across passes
// with per-lane signed saturation. Define PSUM_WB_RELU_EN to zero negative lanes on the final pass.
module psum_writeback #(
   parameter int psum_bw    = 16,
   parameter int col        = 8,
   parameter int len_onij   = 16,
   parameter int addr_width = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start_i,
   input  logic [4:0]             num_pass_i,
   input  logic [col*psum_bw-1:0] d_i,
   input  logic                   d_valid_i,
   output logic                   d_ready_o,
   output logic                   rd_en_o,
   output logic [addr_width-1:0]  rd_addr_o,
   input  logic [col*psum_bw-1:0] rd_data_i,
   output logic                   wr_en_o,
   output logic [addr_width-1:0]  wr_addr_o,
   output logic [col*psum_bw-1:0] wr_data_o,
   output logic                   busy_o,
   output logic                   done_o,
   output logic [4:0]             pass_idx_o
);

   localparam int VW = col * psum_bw;
   localparam logic [addr_width-1:0] LAST_ADDR = addr_width'(len_onij - 1);
`ifdef PSUM_WB_RELU_EN
   localparam bit RELU_EN = 1'b1;
`else
   localparam bit RELU_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FIRST = 3'd1,
      ACC   = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_t;

   // Sign-extend by one bit; the two top bits disagree exactly on overflow.
   function automatic logic [psum_bw-1:0] sat_add(input logic [psum_bw-1:0] a,
                                                  input logic [psum_bw-1:0] b);
      logic [psum_bw:0] sum;
      sum = {a[psum_bw-1], a} + {b[psum_bw-1], b};
      if (sum[psum_bw] != sum[psum_bw-1]) begin
         sat_add = sum[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
      end else begin
         sat_add = sum[psum_bw-1:0];
      end
   endfunction

   function automatic logic [psum_bw-1:0] relu_lane(input logic [psum_bw-1:0] a);
      relu_lane = a[psum_bw-1] ? {psum_bw{1'b0}} : a;
   endfunction

   state_t                state_r;
   logic [addr_width-1:0] addr_r;
   logic [4:0]            pass_idx_r;
   logic [4:0]            num_pass_r;
   logic                  pend_r;
   logic [addr_width-1:0] pend_addr_r;
   logic [VW-1:0]         pend_data_r;
   logic                  pend_last_r;

   logic          acc_s;
   logic          wrap_s;
   logic          last_pass_s;
   logic [VW-1:0] sum_s;
   logic [VW-1:0] wr_raw_s;
   logic          wr_last_s;

   assign d_ready_o   = (state_r == FIRST) || (state_r == ACC);
   assign acc_s       = d_valid_i && d_ready_o;
   assign wrap_s      = (addr_r == LAST_ADDR);
   assign last_pass_s = (pass_idx_r == (num_pass_r - 5'd1));
   assign rd_en_o     = (state_r == ACC) && acc_s;
   assign rd_addr_o   = rd_en_o ? addr_r : {addr_width{1'b0}};
   assign busy_o      = (state_r != IDLE);
   assign done_o      = (state_r == DONE);
   assign pass_idx_o  = pass_idx_r;

   // Job sequencing, address/pass counters and the one-deep pending ACC write.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r     <= IDLE;
         addr_r      <= {addr_width{1'b0}};
         pass_idx_r  <= 5'd0;
         num_pass_r  <= 5'd1;
         pend_r      <= 1'b0;
         pend_addr_r <= {addr_width{1'b0}};
         pend_data_r <= {VW{1'b0}};
         pend_last_r <= 1'b0;
      end else begin
         pend_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start_i) begin
                  state_r    <= FIRST;
                  addr_r     <= {addr_width{1'b0}};
                  pass_idx_r <= 5'd0;
                  num_pass_r <= (num_pass_i == 5'd0) ? 5'd1 : num_pass_i;
               end
            end
            FIRST: begin
               if (acc_s) begin
                  if (wrap_s) begin
                     addr_r     <= {addr_width{1'b0}};
                     pass_idx_r <= pass_idx_r + 5'd1;
                     state_r    <= (num_pass_r > 5'd1) ? ACC : DONE;
                  end else begin
                     addr_r <= addr_r + addr_width'(1);
                  end
               end
            end
            ACC: begin
               if (acc_s) begin
                  pend_r      <= 1'b1;
                  pend_addr_r <= addr_r;
                  pend_data_r <= d_i;
                  pend_last_r <= last_pass_s;
                  if (wrap_s) begin
                     addr_r     <= {addr_width{1'b0}};
                     pass_idx_r <= pass_idx_r + 5'd1;
                     if (last_pass_s) begin
                        state_r <= DRAIN;
                     end
                  end else begin
                     addr_r <= addr_r + addr_width'(1);
                  end
               end
            end
            DRAIN:   state_r <= DONE;
            DONE:    state_r <= IDLE;
            default: state_r <= IDLE;
         endcase
      end
   end

   // Lanewise saturating sum of the SRAM read-back and the held input vector.
   always_comb begin
      sum_s = {VW{1'b0}};
      for (int k = 0; k < col; k++) begin
         sum_s[k*psum_bw +: psum_bw] = sat_add(rd_data_i[k*psum_bw +: psum_bw],
                                               pend_data_r[k*psum_bw +: psum_bw]);
      end
   end

   // Write port source: the retiring ACC write, else a direct FIRST-pass write.
   always_comb begin
      wr_en_o   = 1'b0;
      wr_addr_o = {addr_width{1'b0}};
      wr_raw_s  = {VW{1'b0}};
      wr_last_s = 1'b0;
      if (pend_r) begin
         wr_en_o   = 1'b1;
         wr_addr_o = pend_addr_r;
         wr_raw_s  = sum_s;
         wr_last_s = pend_last_r;
      end else if ((state_r == FIRST) && acc_s) begin
         wr_en_o   = 1'b1;
         wr_addr_o = addr_r;
         wr_raw_s  = d_i;
         wr_last_s = (num_pass_r == 5'd1);
      end else begin
         wr_en_o   = 1'b0;
      end
   end

   // Final-pass clamp, applied after saturation.
   always_comb begin
      wr_data_o = {VW{1'b0}};
      for (int k = 0; k < col; k++) begin
         wr_data_o[k*psum_bw +: psum_bw] = (RELU_EN && wr_last_s) ?
            relu_lane(wr_raw_s[k*psum_bw +: psum_bw]) : wr_raw_s[k*psum_bw +: psum_bw];
      end
   end

endmodule

// File: tb/tb_psum_writeback.sv
// Bench for psum_writeback: SRAM model plus an arithmetic reference of saturating pass accumulation.
`timescale 1ns/1ps
module tb_psum_writeback;

   localparam int PSUM_BW = 16;
   localparam int COL     = 8;
   localparam int LEN     = 16;
   localparam int AW      = 8;
   localparam int VW      = COL * PSUM_BW;
`ifdef PSUM_WB_RELU_EN
   localparam bit RELU = 1'b1;
`else
   localparam bit RELU = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          start_i;
   logic [4:0]    num_pass_i;
   logic [VW-1:0] d_i;
   logic          d_valid_i;
   logic          d_ready_o;
   logic          rd_en_o;
   logic [AW-1:0] rd_addr_o;
   logic [VW-1:0] rd_data_i;
   logic          wr_en_o;
   logic [AW-1:0] wr_addr_o;
   logic [VW-1:0] wr_data_o;
   logic          busy_o;
   logic          done_o;
   logic [4:0]    pass_idx_o;

   always #5 clk = ~clk;

   psum_writeback #(.psum_bw(PSUM_BW), .col(COL), .len_onij(LEN), .addr_width(AW)) dut (
      .clk(clk), .reset(reset), .start_i(start_i), .num_pass_i(num_pass_i),
      .d_i(d_i), .d_valid_i(d_valid_i), .d_ready_o(d_ready_o),
      .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
      .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
      .busy_o(busy_o), .done_o(done_o), .pass_idx_o(pass_idx_o)
   );

   // SRAM with one-cycle read latency
   logic [VW-1:0] mem [0:255];
   always @(posedge clk) begin
      if (rd_en_o) rd_data_i <= mem[rd_addr_o];
      if (wr_en_o) mem[wr_addr_o] <= wr_data_o;
   end

   // Port monitor, sampled mid-cycle
   int cyc = 0;
   int n_rd = 0, n_done = 0, last_wr_cyc = 0, done_cyc = 0;
   logic [AW-1:0] wq_addr [$];
   logic [VW-1:0] wq_data [$];
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (wr_en_o) begin
         wq_addr.push_back(wr_addr_o);
         wq_data.push_back(wr_data_o);
         last_wr_cyc = cyc;
      end
      if (rd_en_o) n_rd++;
      if (done_o) begin
         n_done++;
         done_cyc = cyc;
      end
   end

   int n_checks = 0;
   int n_errors = 0;
   logic [VW-1:0] stim [0:3][0:LEN-1];

   task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [VW-1:0] sat_vec(input logic [VW-1:0] a, input logic [VW-1:0] b);
      logic [VW-1:0] r;
      logic signed [15:0] la, lb;
      int s;
      r = '0;
      for (int k = 0; k < COL; k++) begin
         la = a[k*16 +: 16];
         lb = b[k*16 +: 16];
         s = int'(la) + int'(lb);
         if (s > 32767) s = 32767;
         else if (s < -32768) s = -32768;
         r[k*16 +: 16] = 16'(s);
      end
      return r;
   endfunction

   function automatic logic [VW-1:0] relu_vec(input logic [VW-1:0] a);
      logic [VW-1:0] r;
      r = a;
      for (int k = 0; k < COL; k++) if (a[k*16+15]) r[k*16 +: 16] = 16'd0;
      return r;
   endfunction

   function automatic logic [VW-1:0] gen_vec(input int mode, input int p, input int i);
      logic [VW-1:0] v;
      logic [15:0] lane;
      v = '0;
      for (int k = 0; k < COL; k++) begin
         case (mode)
            0: lane = 16'($urandom);
            1: lane = 16'($urandom_range(0, 200)) - 16'd100;
            2: lane = 16'd5;
            3: lane = 16'(k + 1);
            default: begin
               if (k == 0)      lane = (p == 0) ? 16'h7FF0 : 16'h0020;
               else if (k == 1) lane = (p == 0) ? 16'h8005 : 16'hFFF0;
               else if (k == 2) lane = (p == 0) ? 16'hFFFD : 16'hFFFC;
               else             lane = 16'(i * 3 + k);
            end
         endcase
         v[k*16 +: 16] = lane;
      end
      return v;
   endfunction

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_d_ready"}, d_ready_o, 1'b0);
      chk({tag, "_rd_en"}, rd_en_o, 1'b0);
      chk({tag, "_wr_en"}, wr_en_o, 1'b0);
      chk({tag, "_busy"}, busy_o, 1'b0);
      chk({tag, "_done"}, done_o, 1'b0);
      chk({tag, "_pass_idx"}, pass_idx_o, 5'd0);
      chk({tag, "_rd_addr"}, rd_addr_o, 8'd0);
      chk({tag, "_wr_addr"}, wr_addr_o, 8'd0);
      chk({tag, "_wr_data"}, wr_data_o, {VW{1'b0}});
   endtask

   task automatic run_job(input string name, input int np_in, input int mode,
                          input int gap, input bit noise);
      int np, idx, total, budget, wbase, rbase, dbase, nw;
      logic [VW-1:0] acc [0:LEN-1];
      logic [VW-1:0] ev;
      logic [VW-1:0] exp_d [$];
      logic [AW-1:0] exp_a [$];
      bit took;
      np = (np_in == 0) ? 1 : np_in;
      total = np * LEN;
      for (int p = 0; p < np; p++)
         for (int i = 0; i < LEN; i++) stim[p][i] = gen_vec(mode, p, i);
      // reference: pass 0 stored as-is, later passes saturating-added, clamp on last
      for (int p = 0; p < np; p++)
         for (int i = 0; i < LEN; i++) begin
            acc[i] = (p == 0) ? stim[p][i] : sat_vec(acc[i], stim[p][i]);
            ev = (RELU && p == np - 1) ? relu_vec(acc[i]) : acc[i];
            exp_a.push_back(AW'(i));
            exp_d.push_back(ev);
         end
      wbase = wq_addr.size();
      rbase = n_rd;
      dbase = n_done;

      start_i = 1'b1;
      num_pass_i = 5'(np_in);
      @(posedge clk); #1;
      start_i = 1'b0;
      chk({name, "_busy_start"}, busy_o, 1'b1);
      idx = 0;
      budget = 0;
      while (idx < total && budget < 2000) begin
         d_valid_i = (int'($urandom_range(0, 99)) >= gap);
         d_i = stim[idx / LEN][idx % LEN];
         start_i = noise && ($urandom_range(0, 9) == 0);
         num_pass_i = 5'($urandom);
         took = d_valid_i && d_ready_o;
         if (took) chk({name, "_pass_idx"}, pass_idx_o, 5'(idx / LEN));
         @(posedge clk); #1;
         if (took) idx++;
         budget++;
      end
      start_i = 1'b0;
      chk({name, "_feed_complete"}, idx, total);
      for (int c = 0; c < 8; c++) begin
         d_valid_i = noise;
         d_i = {4{$urandom}};
         if (c == 0) chk({name, "_ready_after_last"}, d_ready_o, 1'b0);
         @(posedge clk); #1;
      end
      d_valid_i = 1'b0;

      chk({name, "_done_count"}, n_done - dbase, 1);
      chk({name, "_done_timing"}, done_cyc, last_wr_cyc + 1);
      chk({name, "_busy_end"}, busy_o, 1'b0);
      chk({name, "_pass_idx_end"}, pass_idx_o, 5'(np));
      chk({name, "_reads"}, n_rd - rbase, (np - 1) * LEN);
      nw = wq_addr.size() - wbase;
      chk({name, "_writes"}, nw, total);
      for (int j = 0; j < nw && j < total; j++) begin
         chk({name, "_wr_addr"}, wq_addr[wbase + j], exp_a[j]);
         chk({name, "_wr_data"}, wq_data[wbase + j], exp_d[j]);
      end
   endtask

   initial begin
      logic [VW-1:0] ramp, m;
      int idx, budget, wb;
      bit took;
      reset = 1'b0;
      start_i = 1'b0;
      num_pass_i = 5'd0;
      d_i = '0;
      d_valid_i = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle_outputs("reset");
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;

      // single pass, ramp lanes: direct writes, done one cycle after the last
      run_job("one_pass", 1, 3, 0, 1'b0);
      for (int k = 0; k < COL; k++) ramp[k*16 +: 16] = 16'(k + 1);
      chk("one_pass_mem15", mem[15], ramp);

      // three passes of 5s, continuous: SRAM ends at 15 per lane
      run_job("three_pass", 3, 2, 0, 1'b0);
      chk("three_pass_mem7", mem[7], {COL{16'd15}});

      run_job("rand_full", 4, 0, 30, 1'b1);
      run_job("np_zero", 0, 1, 50, 1'b1);

      // saturation corners and the final-pass clamp
      run_job("sat", 2, 4, 0, 1'b0);
      m = mem[3];
      chk("sat_pos", m[15:0], 16'h7FFF);
      chk("sat_neg", m[31:16], RELU ? 16'h0000 : 16'h8000);
      chk("relu_m7", m[47:32], RELU ? 16'h0000 : 16'hFFF9);

      run_job("rand_two", 2, 1, 20, 1'b1);

      // reset in pass 2 while an ACC write is pending
      for (int p = 0; p < 2; p++)
         for (int i = 0; i < LEN; i++) stim[p][i] = gen_vec(1, p, i);
      start_i = 1'b1;
      num_pass_i = 5'd2;
      @(posedge clk); #1;
      start_i = 1'b0;
      idx = 0;
      budget = 0;
      while (idx < LEN + 5 && budget < 200) begin
         d_valid_i = 1'b1;
         d_i = stim[idx / LEN][idx % LEN];
         took = d_ready_o;
         @(posedge clk); #1;
         if (took) idx++;
         budget++;
      end
      chk("rst_feed", idx, LEN + 5);
      chk("rst_pending_wr", wr_en_o, 1'b1);
      wb = wq_addr.size();
      reset = 1'b0;
      start_i = 1'b1;
      #1;
      check_idle_outputs("midjob_rst");
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_no_write", wq_addr.size(), wb);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_mem4_kept", mem[4], stim[0][4]);
      @(posedge clk); #1;
      start_i = 1'b0;
      d_valid_i = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_idle", busy_o, 1'b0);

      run_job("after_rst", 2, 0, 10, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
